// File: rtl/simpleadder_arbiter.sv
// simpleadder_arbiter
//   Shares one simpleadder datapath between N_REQ requesters. A round-robin
//   scan picks one requester, latches its operands, and issues a single
//   operation to the adder. It then waits for the adder's result, or for a
//   timeout, and returns the response to the requester that won. Only one
//   transaction is in flight at a time, and every output is a register.
//
// Ports
//   sig_clock  in   clock, posedge
//   sig_rst    in   asynchronous reset, active low
//   req_valid  in   [N_REQ]         per-requester request, held until req_ready
//   req_op     in   [2*N_REQ]       per-requester op (00 add, 01 sub, 1x illegal)
//   req_ina    in   [DATA_W*N_REQ]  per-requester operand A
//   req_inb    in   [DATA_W*N_REQ]  per-requester operand B
//   req_ready  out  [N_REQ]         one-hot accept pulse
//   rsp_valid  out  [N_REQ]         one-hot response pulse
//   rsp_data   out  [DATA_W+1]      result, valid with rsp_valid
//   rsp_err    out  1               illegal op or timeout, valid with rsp_valid
//   busy       out  1               transaction issued or awaiting result
//   sig_en_i   out  1               adder operation enable (one-cycle pulse)
//   operation  out  [2]             adder op code
//   sig_ina    out  [DATA_W]        adder operand A
//   sig_inb    out  [DATA_W]        adder operand B
//   sig_en_o   in   1               adder result valid
//   sig_out    in   [DATA_W+1]      adder result
module simpleadder_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      sig_clock,
  input  logic                      sig_rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [2*N_REQ-1:0]        req_op,
  input  logic [DATA_W*N_REQ-1:0]   req_ina,
  input  logic [DATA_W*N_REQ-1:0]   req_inb,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W:0]           rsp_data,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      sig_en_i,
  output logic [1:0]                operation,
  output logic [DATA_W-1:0]         sig_ina,
  output logic [DATA_W-1:0]         sig_inb,
  input  logic                      sig_en_o,
  input  logic [DATA_W:0]           sig_out
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [1:0]         opLat_q, opLat_d;
  logic [DATA_W-1:0]  inaLat_q, inaLat_d;
  logic [DATA_W-1:0]  inbLat_q, inbLat_d;
  logic [7:0]         waitCnt_q, waitCnt_d;
  logic               illegalPend_q, illegalPend_d;
  logic [N_REQ-1:0]   reqReady_q, reqReady_d;
  logic [N_REQ-1:0]   rspValid_q, rspValid_d;
  logic [DATA_W:0]    rspData_q, rspData_d;
  logic               rspErr_q, rspErr_d;
  logic               busy_q, busy_d;
  logic               enIssue_q, enIssue_d;

  logic [1:0]         reqOpArr  [N_REQ];
  logic [DATA_W-1:0]  reqInaArr [N_REQ];
  logic [DATA_W-1:0]  reqInbArr [N_REQ];

  logic               scanFound;
  logic [PTR_W-1:0]   scanIdx;
  int                 scanPos;
  logic [N_REQ-1:0]   scanOneHot;
  logic [N_REQ-1:0]   winnerOneHot;

  // Split the flat per-requester buses into arrays for indexed selection.
  for (genvar g = 0; g < N_REQ; g++) begin : gUnpack
    assign reqOpArr[g]  = req_op[2*g +: 2];
    assign reqInaArr[g] = req_ina[DATA_W*g +: DATA_W];
    assign reqInbArr[g] = req_inb[DATA_W*g +: DATA_W];
  end

  // Round-robin scan: first valid request starting at rrPtr_q and wrapping.
  always_comb begin
    scanFound = 1'b0;
    scanIdx   = '0;
    scanPos   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      scanPos = (int'(rrPtr_q) + i) % N_REQ;
      if (!scanFound && req_valid[PTR_W'(scanPos)]) begin
        scanFound = 1'b1;
        scanIdx   = PTR_W'(scanPos);
      end
    end
  end

  assign scanOneHot   = {{(N_REQ-1){1'b0}}, 1'b1} << scanIdx;
  assign winnerOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << winner_q;

  // Next-state and output decode. Pulse outputs default low every cycle.
  // After an illegal op is accepted, the following IDLE cycle only emits the
  // error response. It does not grant, because the requester that was just
  // accepted is still holding req_valid during that cycle.
  always_comb begin
    state_d       = state_q;
    rrPtr_d       = rrPtr_q;
    winner_d      = winner_q;
    opLat_d       = opLat_q;
    inaLat_d      = inaLat_q;
    inbLat_d      = inbLat_q;
    waitCnt_d     = waitCnt_q;
    illegalPend_d = 1'b0;
    reqReady_d    = '0;
    rspValid_d    = '0;
    rspData_d     = '0;
    rspErr_d      = 1'b0;
    busy_d        = 1'b0;
    enIssue_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (illegalPend_q) begin
          rspValid_d = winnerOneHot;
          rspErr_d   = 1'b1;
        end else if (scanFound) begin
          winner_d   = scanIdx;
          reqReady_d = scanOneHot;
          opLat_d    = reqOpArr[scanIdx];
          inaLat_d   = reqInaArr[scanIdx];
          inbLat_d   = reqInbArr[scanIdx];
          rrPtr_d    = PTR_W'((int'(scanIdx) + 1) % N_REQ);
          if (!reqOpArr[scanIdx][1]) begin
            state_d = ISSUE;
            busy_d  = 1'b1;
          end else begin
            illegalPend_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        enIssue_d = 1'b1;
        busy_d    = 1'b1;
        waitCnt_d = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        busy_d = 1'b1;
        if (sig_en_o) begin
          rspValid_d = winnerOneHot;
          rspData_d  = sig_out;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else if (waitCnt_q == 8'(TIMEOUT - 1)) begin
          rspValid_d = winnerOneHot;
          rspErr_d   = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops any in-flight operation silently.
  always_ff @(posedge sig_clock or negedge sig_rst) begin
    if (!sig_rst) begin
      state_q       <= IDLE;
      rrPtr_q       <= '0;
      winner_q      <= '0;
      opLat_q       <= '0;
      inaLat_q      <= '0;
      inbLat_q      <= '0;
      waitCnt_q     <= '0;
      illegalPend_q <= 1'b0;
      reqReady_q    <= '0;
      rspValid_q    <= '0;
      rspData_q     <= '0;
      rspErr_q      <= 1'b0;
      busy_q        <= 1'b0;
      enIssue_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rrPtr_q       <= rrPtr_d;
      winner_q      <= winner_d;
      opLat_q       <= opLat_d;
      inaLat_q      <= inaLat_d;
      inbLat_q      <= inbLat_d;
      waitCnt_q     <= waitCnt_d;
      illegalPend_q <= illegalPend_d;
      reqReady_q    <= reqReady_d;
      rspValid_q    <= rspValid_d;
      rspData_q     <= rspData_d;
      rspErr_q      <= rspErr_d;
      busy_q        <= busy_d;
      enIssue_q     <= enIssue_d;
    end
  end

  assign req_ready = reqReady_q;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_err   = rspErr_q;
  assign busy      = busy_q;
  assign sig_en_i  = enIssue_q;
  assign operation = opLat_q;
  assign sig_ina   = inaLat_q;
  assign sig_inb   = inbLat_q;

endmodule

// File: tb/tb_simpleadder_arbiter.sv
// tb_simpleadder_arbiter
//   Scoreboard bench for simpleadder_arbiter. Requesters are modelled as
//   counters of outstanding transactions. A two-stage adder model sits on the
//   adder port. A monitor compares every grant and response against the
//   expected entries queued by the directed stimulus.
module tb_simpleadder_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    int          idx;
    logic [8:0]  data;
    logic        err;
  } rspExp_t;

  logic                    sig_clock = 1'b0;
  logic                    sig_rst   = 1'b0;
  logic [N_REQ-1:0]        req_valid;
  logic [2*N_REQ-1:0]      req_op;
  logic [DATA_W*N_REQ-1:0] req_ina;
  logic [DATA_W*N_REQ-1:0] req_inb;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W:0]         rsp_data;
  logic                    rsp_err;
  logic                    busy;
  logic                    sig_en_i;
  logic [1:0]              operation;
  logic [DATA_W-1:0]       sig_ina;
  logic [DATA_W-1:0]       sig_inb;
  logic                    sig_en_o;
  logic [DATA_W:0]         sig_out;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;

  int          reqTotal [N_REQ] = '{default: 0};
  int          reqDone  [N_REQ] = '{default: 0};
  logic [1:0]  reqOpS   [N_REQ] = '{default: 2'b00};
  logic [7:0]  reqAS    [N_REQ] = '{default: 8'h00};
  logic [7:0]  reqBS    [N_REQ] = '{default: 8'h00};

  int          grantQ [$];
  rspExp_t     rspQ   [$];
  int          grantSeen = 0;
  int          rspSeen   = 0;
  int          enCount   = 0;
  int          enCycle   = 0;
  int          grantCycle [N_REQ] = '{default: 0};
  int          rspCycle   [N_REQ] = '{default: 0};

  logic        adderDead = 1'b0;
  logic        st1En;
  logic [8:0]  st1Res;

  simpleadder_arbiter #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sig_clock (sig_clock),
    .sig_rst   (sig_rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ina   (req_ina),
    .req_inb   (req_inb),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .sig_en_i  (sig_en_i),
    .operation (operation),
    .sig_ina   (sig_ina),
    .sig_inb   (sig_inb),
    .sig_en_o  (sig_en_o),
    .sig_out   (sig_out)
  );

  always #5 sig_clock = ~sig_clock;

  always @(posedge sig_clock) cycle <= cycle + 1;

  // A requester is active while it has issued more transactions than it has
  // seen accepted.
  for (genvar g = 0; g < N_REQ; g++) begin : gReq
    assign req_valid[g]              = (reqDone[g] != reqTotal[g]);
    assign req_op[2*g +: 2]          = reqOpS[g];
    assign req_ina[DATA_W*g +: DATA_W] = reqAS[g];
    assign req_inb[DATA_W*g +: DATA_W] = reqBS[g];
  end

  // Requester side: an accept seen in a cycle retires one transaction just
  // after the following clock edge.
  always begin : driver
    logic [N_REQ-1:0] seen;
    @(negedge sig_clock);
    seen = req_ready;
    @(posedge sig_clock);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (seen[i]) reqDone[i] = reqDone[i] + 1;
    end
  end

  // Adder model: result valid two cycles after the enable pulse.
  always @(posedge sig_clock or negedge sig_rst) begin
    if (!sig_rst) begin
      st1En    <= 1'b0;
      st1Res   <= '0;
      sig_en_o <= 1'b0;
      sig_out  <= '0;
    end else begin
      st1En    <= sig_en_i & ~adderDead;
      st1Res   <= (operation == 2'b01) ? ({1'b0, sig_ina} - {1'b0, sig_inb})
                                       : ({1'b0, sig_ina} + {1'b0, sig_inb});
      sig_en_o <= st1En;
      sig_out  <= st1Res;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [1:0] op,
                               input logic [7:0] a, input logic [7:0] b);
    reqOpS[idx]   = op;
    reqAS[idx]    = a;
    reqBS[idx]    = b;
    reqTotal[idx] = reqTotal[idx] + 1;
  endtask

  task automatic expectTxn(input int idx, input logic [8:0] data, input logic err);
    rspExp_t e;
    e.idx  = idx;
    e.data = data;
    e.err  = err;
    grantQ.push_back(idx);
    rspQ.push_back(e);
  endtask

  function automatic int pickCounter(input int which);
    case (which)
      0:       return rspSeen;
      1:       return enCount;
      default: return grantSeen;
    endcase
  endfunction

  task automatic waitFor(input int which, input int target, input int budget,
                         input string name);
    int n;
    int cur;
    n   = 0;
    cur = pickCounter(which);
    while (cur < target && n < budget) begin
      @(negedge sig_clock);
      #1;
      n   = n + 1;
      cur = pickCounter(which);
    end
    checkOutput(name, 32'(cur >= target), 32'd1);
  endtask

  // Monitor: checks every grant and response against the scoreboard queues
  // and records when they happened, for the latency checks.
  always @(negedge sig_clock) begin : monitor
    int      idx;
    int      expIdx;
    logic    have;
    rspExp_t e;
    if (sig_rst) begin
      if (req_ready != '0) begin
        checkOutput("grantOnehot", 32'($onehot(req_ready)), 32'd1);
        idx = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) idx = i;
        grantCycle[idx] = cycle;
        grantSeen       = grantSeen + 1;
        have = (grantQ.size() > 0);
        checkOutput("grantExpected", 32'(have), 32'd1);
        if (have) begin
          expIdx = grantQ.pop_front();
          checkOutput("grantOrder", idx, expIdx);
        end
      end
      if (rsp_valid != '0) begin
        checkOutput("rspOnehot", 32'($onehot(rsp_valid)), 32'd1);
        idx = 0;
        for (int i = 0; i < N_REQ; i++) if (rsp_valid[i]) idx = i;
        rspCycle[idx] = cycle;
        rspSeen       = rspSeen + 1;
        have = (rspQ.size() > 0);
        checkOutput("rspExpected", 32'(have), 32'd1);
        if (have) begin
          e = rspQ.pop_front();
          checkOutput("rspRequester", idx, e.idx);
          checkOutput("rspData", 32'(rsp_data), 32'(e.data));
          checkOutput("rspErr", 32'(rsp_err), 32'(e.err));
        end
      end
      if (sig_en_i) begin
        enCycle = cycle;
        enCount = enCount + 1;
        checkOutput("busyWithEnable", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    int enBefore;

    // Reset state.
    repeat (3) @(posedge sig_clock);
    @(negedge sig_clock);
    checkOutput("resetOutputsZero",
                32'(|{req_ready, rsp_valid, rsp_data, rsp_err, busy, sig_en_i,
                      operation, sig_ina, sig_inb}), 32'd0);
    #2 sig_rst = 1'b1;

    // Reset in the middle of WAIT: outputs clear at once, and the in-flight
    // op produces no response.
    @(posedge sig_clock);
    #2;
    grantQ.push_back(1);
    applyStimulus(1, 2'b00, 8'h11, 8'h22);
    waitFor(1, 1, 20, "enableBeforeReset");
    @(negedge sig_clock);
    #2 sig_rst = 1'b0;
    #1;
    checkOutput("midResetOutputsZero",
                32'(|{req_ready, rsp_valid, rsp_data, rsp_err, busy, sig_en_i,
                      operation, sig_ina, sig_inb}), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    repeat (2) @(posedge sig_clock);
    @(negedge sig_clock);
    #2 sig_rst = 1'b1;
    repeat (8) @(negedge sig_clock);
    #1;
    checkOutput("noRspAfterReset", rspSeen, 0);

    // After reset the pointer is back at 0, so req 0 wins over req 2.
    @(posedge sig_clock);
    #2;
    expectTxn(0, 9'h003, 1'b0);
    expectTxn(2, 9'h01E, 1'b0);
    applyStimulus(0, 2'b00, 8'h01, 8'h02);
    applyStimulus(2, 2'b00, 8'h0A, 8'h14);
    waitFor(0, 2, 40, "rrAfterResetDone");

    // Single add with latency checks.
    @(posedge sig_clock);
    #2;
    expectTxn(2, 9'h080, 1'b0);
    applyStimulus(2, 2'b00, 8'h7F, 8'h01);
    waitFor(0, 3, 30, "addDone");
    checkOutput("addEnableLatency", enCycle - grantCycle[2], 1);
    checkOutput("addRspLatency", rspCycle[2] - grantCycle[2], 4);

    // Subtraction wraps modulo 2^9.
    @(posedge sig_clock);
    #2;
    expectTxn(0, 9'h1FE, 1'b0);
    applyStimulus(0, 2'b01, 8'h03, 8'h05);
    waitFor(0, 4, 30, "subDone");

    // Illegal op: no adder access, error response one cycle after accept.
    @(posedge sig_clock);
    #2;
    enBefore = enCount;
    expectTxn(1, 9'h000, 1'b1);
    applyStimulus(1, 2'b10, 8'hAA, 8'h55);
    waitFor(0, 5, 30, "illegalDone");
    checkOutput("illegalNoEnable", enCount, enBefore);
    checkOutput("illegalRspLatency", rspCycle[1] - grantCycle[1], 1);

    // Timeout: the adder never answers.
    @(posedge sig_clock);
    #2;
    adderDead = 1'b1;
    expectTxn(3, 9'h000, 1'b1);
    applyStimulus(3, 2'b00, 8'h01, 8'h01);
    waitFor(0, 6, 60, "timeoutDone");
    checkOutput("timeoutEnableLatency", enCycle - grantCycle[3], 1);
    checkOutput("timeoutRspLatency", rspCycle[3] - grantCycle[3], TIMEOUT + 1);
    adderDead = 1'b0;

    // Round robin with every requester active: order 0,1,2,3,0.
    @(posedge sig_clock);
    #2;
    expectTxn(0, 9'h030, 1'b0);
    expectTxn(1, 9'h1FE, 1'b0);
    expectTxn(2, 9'h100, 1'b0);
    expectTxn(3, 9'h1FF, 1'b1 & 1'b0);
    expectTxn(0, 9'h030, 1'b0);
    applyStimulus(0, 2'b00, 8'h10, 8'h20);
    applyStimulus(1, 2'b00, 8'hFF, 8'hFF);
    applyStimulus(2, 2'b00, 8'h80, 8'h80);
    applyStimulus(3, 2'b01, 8'h00, 8'h01);
    applyStimulus(0, 2'b00, 8'h10, 8'h20);
    waitFor(0, 11, 120, "roundRobinDone");

    repeat (4) @(negedge sig_clock);
    checkOutput("grantQueueDrained", grantQ.size(), 0);
    checkOutput("rspQueueDrained", rspQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
